// File: rtl/iso14443a_frame_decode.sv
// Modified-Miller frame decoder: turns X/Y/Z/ERROR sequences into SOC/EOC, LSb-first bytes and error flags.
// Latency: every output is registered and appears one cycle after the causing sd_seq_valid strobe.
package ISO14443A_pkg;
    typedef enum logic [1:0] {X = 2'd0, Y = 2'd1, Z = 2'd2, ERROR = 2'd3} PCDBitSequence;
endpackage

module iso14443a_frame_decode
    import ISO14443A_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  PCDBitSequence sd_seq,
    input  logic          sd_seq_valid,
    output logic          soc,
    output logic          eoc,
    output logic [7:0]    data,
    output logic [2:0]    data_bits,
    output logic          data_valid,
    output logic          sequence_error,
    output logic          parity_error
);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_ERR} state_t;

    state_t        state_q, state_d;
    PCDBitSequence last_seq_q, last_seq_d;
    logic          prev_bit_q, prev_bit_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_bit_q, pend_bit_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic          byte_seen_q, byte_seen_d;
    logic          soc_q, soc_d;
    logic          eoc_q, eoc_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    data_bits_q, data_bits_d;
    logic          data_valid_q, data_valid_d;
    logic          seq_err_q, seq_err_d;
    logic          par_err_q, par_err_d;

    logic          is_bit, is_eoc, is_err, dec_bit;

    // Classify the incoming sequence against the previous decoded value (SOC acts as a 0).
    always_comb begin
        is_bit  = 1'b0;
        is_eoc  = 1'b0;
        is_err  = 1'b0;
        dec_bit = 1'b0;
        case (sd_seq)
            X:       begin is_bit = 1'b1; dec_bit = 1'b1; end
            Y:       begin if (prev_bit_q) is_bit = 1'b1; else is_eoc = 1'b1; end
            Z:       begin if (prev_bit_q) is_err = 1'b1; else is_bit = 1'b1; end
            default: is_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_seq_d   = last_seq_q;
        prev_bit_d   = prev_bit_q;
        pend_vld_d   = pend_vld_q;
        pend_bit_d   = pend_bit_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        par_d        = par_q;
        byte_seen_d  = byte_seen_q;
        soc_d        = 1'b0;
        eoc_d        = 1'b0;
        data_d       = data_q;
        data_bits_d  = data_bits_q;
        data_valid_d = 1'b0;
        seq_err_d    = 1'b0;
        par_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sd_seq_valid && sd_seq == Z) begin
                    soc_d       = 1'b1;
                    state_d     = S_RX;
                    prev_bit_d  = 1'b0;
                    pend_vld_d  = 1'b0;
                    cnt_d       = 4'd0;
                    sr_d        = 8'd0;
                    par_d       = 1'b0;
                    byte_seen_d = 1'b0;
                end
            end
            S_RX: begin
                if (sd_seq_valid) begin
                    last_seq_d = sd_seq;
                    if (is_err) begin
                        seq_err_d = 1'b1;
                        state_d   = S_ERR;
                    end else if (is_eoc) begin
                        // The pending bit is the 0 that belongs to the EOC pattern; it is dropped.
                        eoc_d       = 1'b1;
                        state_d     = S_IDLE;
                        data_bits_d = 3'd0;
                        if (cnt_q == 4'd0) begin
                            seq_err_d = ~byte_seen_q;
                        end else if (cnt_q == 4'd8) begin
                            par_err_d = 1'b1;
                        end else begin
                            data_valid_d = 1'b1;
                            data_d       = sr_q;
                            data_bits_d  = cnt_q[2:0];
                        end
                    end else if (is_bit) begin
                        pend_bit_d = dec_bit;
                        pend_vld_d = 1'b1;
                        prev_bit_d = dec_bit;
                        if (pend_vld_q) begin
                            if (cnt_q == 4'd8) begin
                                if (par_q ^ pend_bit_q) begin
                                    data_valid_d = 1'b1;
                                    data_d       = sr_q;
                                    data_bits_d  = 3'd0;
                                    cnt_d        = 4'd0;
                                    sr_d         = 8'd0;
                                    par_d        = 1'b0;
                                    byte_seen_d  = 1'b1;
                                end else begin
                                    par_err_d = 1'b1;
                                    state_d   = S_ERR;
                                end
                            end else begin
                                sr_d[cnt_q[2:0]] = pend_bit_q;
                                par_d            = par_q ^ pend_bit_q;
                                cnt_d            = cnt_q + 4'd1;
                            end
                        end
                    end
                end
            end
            S_ERR: begin
                if (sd_seq_valid) begin
                    last_seq_d = sd_seq;
                    if (sd_seq == Y && (last_seq_q == Y || last_seq_q == Z)) begin
                        eoc_d       = 1'b1;
                        data_bits_d = 3'd0;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_seq_q   <= X;
            prev_bit_q   <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_bit_q   <= 1'b0;
            cnt_q        <= 4'd0;
            sr_q         <= 8'd0;
            par_q        <= 1'b0;
            byte_seen_q  <= 1'b0;
            soc_q        <= 1'b0;
            eoc_q        <= 1'b0;
            data_q       <= 8'd0;
            data_bits_q  <= 3'd0;
            data_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
            par_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_seq_q   <= last_seq_d;
            prev_bit_q   <= prev_bit_d;
            pend_vld_q   <= pend_vld_d;
            pend_bit_q   <= pend_bit_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            par_q        <= par_d;
            byte_seen_q  <= byte_seen_d;
            soc_q        <= soc_d;
            eoc_q        <= eoc_d;
            data_q       <= data_d;
            data_bits_q  <= data_bits_d;
            data_valid_q <= data_valid_d;
            seq_err_q    <= seq_err_d;
            par_err_q    <= par_err_d;
        end
    end

    assign soc            = soc_q;
    assign eoc            = eoc_q;
    assign data           = data_q;
    assign data_bits      = data_bits_q;
    assign data_valid     = data_valid_q;
    assign sequence_error = seq_err_q;
    assign parity_error   = par_err_q;

endmodule

// File: tb/tb_iso14443a_frame_decode.sv
// Directed bench for iso14443a_frame_decode: sequence frames in, observed pulses compared to hand-computed values.
module tb_iso14443a_frame_decode;
    import ISO14443A_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    PCDBitSequence sd_seq;
    logic          sd_seq_valid;
    logic          soc, eoc, data_valid, sequence_error, parity_error;
    logic [7:0]    data;
    logic [2:0]    data_bits;

    iso14443a_frame_decode dut (
        .clk(clk), .rst_n(rst_n), .sd_seq(sd_seq), .sd_seq_valid(sd_seq_valid),
        .soc(soc), .eoc(eoc), .data(data), .data_bits(data_bits), .data_valid(data_valid),
        .sequence_error(sequence_error), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: counts pulses, collects mid-frame bytes and the fields seen at eoc.
    logic       clr = 1'b0;
    int         soc_n, eoc_n, seq_n, par_n, dvbits_bad;
    logic [7:0] dv_q[$];
    logic [7:0] eoc_data;
    logic [2:0] eoc_bits;
    logic       eoc_dv, eoc_se, eoc_pe;

    always @(negedge clk) begin
        if (clr) begin
            soc_n <= 0; eoc_n <= 0; seq_n <= 0; par_n <= 0; dvbits_bad <= 0;
            dv_q.delete();
            eoc_data <= 8'h00; eoc_bits <= 3'd0; eoc_dv <= 1'b0; eoc_se <= 1'b0; eoc_pe <= 1'b0;
        end else begin
            if (soc) soc_n <= soc_n + 1;
            if (sequence_error) seq_n <= seq_n + 1;
            if (parity_error) par_n <= par_n + 1;
            if (data_valid && !eoc) begin
                dv_q.push_back(data);
                if (data_bits != 3'd0) dvbits_bad <= dvbits_bad + 1;
            end
            if (eoc) begin
                eoc_n <= eoc_n + 1;
                eoc_data <= data; eoc_bits <= data_bits; eoc_dv <= data_valid;
                eoc_se <= sequence_error; eoc_pe <= parity_error;
            end
        end
    end

    // Frame builder: modified-Miller encoding of a bit list into sequences.
    PCDBitSequence sq[$];
    logic          prv;

    task automatic f_start();
        sq.delete(); sq.push_back(Z); prv = 1'b0;
    endtask
    task automatic f_bit(input logic b);
        if (b) sq.push_back(X); else sq.push_back(prv ? Y : Z);
        prv = b;
    endtask
    task automatic f_byte(input logic [7:0] v, input logic par_ok, input logic with_par);
        for (int i = 0; i < 8; i++) f_bit(v[i]);
        if (with_par) f_bit((~^v) ^ ~par_ok);
    endtask
    task automatic f_end();
        f_bit(1'b0); sq.push_back(Y);
    endtask

    task automatic mon_clear();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    // Each strobe is followed by an idle cycle carrying Z, which must be ignored.
    task automatic send(input PCDBitSequence s);
        @(posedge clk); #1;
        sd_seq = s; sd_seq_valid = 1'b1;
        @(posedge clk); #1;
        sd_seq_valid = 1'b0; sd_seq = Z;
    endtask

    task automatic run();
        mon_clear();
        foreach (sq[i]) send(sq[i]);
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] dv_at(input int i);
        return (dv_q.size() > i) ? {1'b0, dv_q[i]} : 9'h1FF;
    endfunction

    task automatic chk_frame(input string tag, input int n_dv, input int n_seq, input int n_par,
                             input logic [2:0] e_bits, input logic e_dv, input logic [7:0] e_data,
                             input logic e_se, input logic e_pe);
        chk({tag, ".soc"}, soc_n, 1);
        chk({tag, ".eoc"}, eoc_n, 1);
        chk({tag, ".ndv"}, dv_q.size(), n_dv);
        chk({tag, ".nseq"}, seq_n, n_seq);
        chk({tag, ".npar"}, par_n, n_par);
        chk({tag, ".dvbits"}, dvbits_bad, 0);
        chk({tag, ".eoc_fields"}, {eoc_bits, eoc_dv, eoc_se, eoc_pe}, {e_bits, e_dv, e_se, e_pe});
        if (e_dv) chk({tag, ".eoc_data"}, eoc_data, e_data);
    endtask

    initial begin
        rst_n = 1'b0; sd_seq = X; sd_seq_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {soc, eoc, data, data_bits, data_valid, sequence_error, parity_error}, 0);
        rst_n = 1'b1;

        // Reference frame: one byte 0x29, clean end.
        sq = '{Z, X, Y, Z, X, Y, X, Y, Z, Z, Z, Y};
        run();
        chk_frame("ref", 1, 0, 0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ref.byte0", dv_at(0), 9'h029);

        // Good parity byte.
        f_start(); f_byte(8'hA5, 1'b1, 1'b1); f_end(); run();
        chk_frame("par_ok", 1, 0, 0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("par_ok.byte0", dv_at(0), 9'h0A5);

        // Same byte with flipped parity bit.
        f_start(); f_byte(8'hA5, 1'b0, 1'b1); f_end(); run();
        chk_frame("par_bad", 0, 0, 1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Eight data bits, parity missing.
        f_start(); f_byte(8'h3C, 1'b1, 1'b0); f_end(); run();
        chk_frame("no_par", 0, 0, 1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);

        // ERROR in each bit position of a valid one-byte frame.
        for (int k = 1; k <= 9; k++) begin
            f_start(); f_byte(8'hA5, 1'b1, 1'b1); f_end();
            sq[k] = ERROR;
            run();
            chk_frame($sformatf("err_pos%0d", k), 0, 1, 0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Empty frames; the trailing Y of ZYY must be ignored in IDLE.
        sq = '{Z, Y, Y}; run();
        chk_frame("zyy", 0, 1, 0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        sq = '{Z, Z, Y}; run();
        chk_frame("zzy", 0, 1, 0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Partial final bytes.
        f_start(); f_bit(1'b1); f_bit(1'b0); f_bit(1'b1); f_end(); run();
        chk_frame("part3", 0, 0, 0, 3'd3, 1'b1, 8'h05, 1'b0, 1'b0);
        f_start(); for (int i = 0; i < 7; i++) f_bit(i == 0 || i == 1 || i == 3 || i == 6); f_end(); run();
        chk_frame("part7", 0, 0, 0, 3'd7, 1'b1, 8'h4B, 1'b0, 1'b0);
        f_start(); f_byte(8'h5A, 1'b1, 1'b1);
        f_bit(1'b1); f_bit(1'b1); f_bit(1'b0); f_bit(1'b0); f_bit(1'b1); f_end(); run();
        chk_frame("byte_part5", 1, 0, 0, 3'd5, 1'b1, 8'h13, 1'b0, 1'b0);
        chk("byte_part5.byte0", dv_at(0), 9'h05A);

        // Two full bytes, no trailing bits.
        f_start(); f_byte(8'hFF, 1'b1, 1'b1); f_byte(8'h00, 1'b1, 1'b1); f_end(); run();
        chk_frame("two_bytes", 2, 0, 0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("two_bytes.byte0", dv_at(0), 9'h0FF);
        chk("two_bytes.byte1", dv_at(1), 9'h000);

        // Broken parity in a middle byte: only the first byte comes out, then a clean eoc.
        f_start(); f_byte(8'h11, 1'b1, 1'b1); f_byte(8'h22, 1'b0, 1'b1); f_byte(8'h33, 1'b1, 1'b1);
        f_bit(1'b1); f_bit(1'b1); f_bit(1'b0); f_end(); run();
        chk_frame("mid_par", 1, 0, 1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_par.byte0", dv_at(0), 9'h011);

        // Reset mid-frame: no eoc, back to IDLE where X/Y are ignored.
        mon_clear();
        send(Z); send(X); send(X);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_outputs", {soc, eoc, data, data_bits, data_valid, sequence_error, parity_error}, 0);
        rst_n = 1'b1;
        mon_clear();
        send(Y); send(Y); send(X);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_idle", {soc_n[7:0], eoc_n[7:0], seq_n[7:0]}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
